// File: rtl/bp_lce_req_arb_pkg.sv
// Shared defaults and width helpers for the LCE request arbiter.
package bp_lce_req_arb_pkg;

  localparam int unsigned lce_req_arb_num_req_dflt = 2;
  localparam int unsigned lce_req_arb_credits_dflt = 4;
  localparam int unsigned lce_req_arb_width_dflt   = 64;
  localparam int unsigned grant_cnt_width_lp       = 32;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned count_width(input int unsigned max_val);
    return safe_clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/bp_lce_req_arb_chk.sv
// Protocol checks for the LCE request arbiter (credit underflow, grant legality).
module bp_lce_req_arb_chk #(
  parameter int unsigned num_req_p = 2
)(
  input logic                 clk_i,
  input logic                 reset_i,
  input logic [num_req_p-1:0] req_ready_i,
  input logic [num_req_p-1:0] credit_return_i,
  input logic [num_req_p-1:0] credits_empty_i,
  input logic [num_req_p-1:0] credits_full_i
);

  a_no_credit_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (credit_return_i & credits_empty_i) == '0);

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(req_ready_i));

  a_no_grant_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    (req_ready_i & credits_full_i) == '0);

endmodule

// File: rtl/bp_lce_req_arb_credit.sv
// Outstanding-request credit counter for one requester; full/empty decode the registered count.
module bp_lce_req_arb_credit
  import bp_lce_req_arb_pkg::*;
#(
  parameter int unsigned credits_p = lce_req_arb_credits_dflt
)(
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned cnt_w_lp = count_width(credits_p);

  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc/dec cancel; a decrement at zero saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != cnt_w_lp'(credits_p)) begin
        cnt_d = cnt_q + cnt_w_lp'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - cnt_w_lp'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == cnt_w_lp'(credits_p));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bp_lce_req_arb.sv
// Round-robin LCE request arbiter with a single-entry output buffer and per-requester credits.
// Optional per-requester grant counters are built when BP_LCE_REQ_ARB_STATS_EN is defined.
module bp_lce_req_arb
  import bp_lce_req_arb_pkg::*;
#(
  parameter int unsigned num_req_p   = lce_req_arb_num_req_dflt,
  parameter int unsigned credits_p   = lce_req_arb_credits_dflt,
  parameter int unsigned req_width_p = lce_req_arb_width_dflt
)(
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_req_p*req_width_p-1:0]        req_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  output logic [num_req_p-1:0]                    req_ready_o,
  input  logic [num_req_p-1:0]                    credit_return_i,
  output logic [num_req_p-1:0]                    credits_full_o,
  output logic [num_req_p-1:0]                    credits_empty_o,
  output logic [req_width_p-1:0]                  lce_req_o,
  output logic                                    lce_req_v_o,
  input  logic                                    lce_req_ready_i,
  output logic [num_req_p*grant_cnt_width_lp-1:0] grant_count_o
);

  localparam int unsigned ptr_w_lp = safe_clog2(num_req_p);
  localparam logic [ptr_w_lp:0] num_req_lp = (ptr_w_lp+1)'(num_req_p);

  logic [ptr_w_lp-1:0]    ptr_q, ptr_d;
  logic                   full_q;
  logic [req_width_p-1:0] data_q;
  logic                   can_load_s;
  logic [num_req_p-1:0]   elig_s, grant_s;
  logic                   grant_v_s;
  logic [ptr_w_lp-1:0]    grant_idx_s;
  logic [ptr_w_lp:0]      rr_idx_s;
  logic [req_width_p-1:0] grant_data_s;

  // A draining network frees the buffer in the same cycle, so full throughput is kept.
  assign can_load_s = ~full_q | lce_req_ready_i;
  assign elig_s     = req_v_i & ~credits_full_o & {num_req_p{can_load_s & ~reset_i}};

  // Round-robin search upward from the priority pointer, wrapping at num_req_p.
  always_comb begin
    grant_v_s   = 1'b0;
    grant_idx_s = '0;
    rr_idx_s    = '0;
    for (int k = 0; k < int'(num_req_p); k++) begin
      rr_idx_s = {1'b0, ptr_q} + (ptr_w_lp+1)'(k);
      if (rr_idx_s >= num_req_lp) begin
        rr_idx_s = rr_idx_s - num_req_lp;
      end else begin
        rr_idx_s = rr_idx_s;
      end
      if (!grant_v_s && elig_s[rr_idx_s[ptr_w_lp-1:0]]) begin
        grant_v_s   = 1'b1;
        grant_idx_s = rr_idx_s[ptr_w_lp-1:0];
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // One-hot grant decode and payload select.
  always_comb begin
    grant_s      = '0;
    grant_data_s = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      if (grant_v_s && (grant_idx_s == ptr_w_lp'(i))) begin
        grant_s[i]   = 1'b1;
        grant_data_s = req_i[i*req_width_p +: req_width_p];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // Pointer advances past the winner only when a transfer happens.
  always_comb begin
    if (grant_v_s) begin
      if (grant_idx_s == ptr_w_lp'(num_req_p - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_s + ptr_w_lp'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Output buffer and priority pointer state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      ptr_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (grant_v_s) begin
        full_q <= 1'b1;
        data_q <= grant_data_s;
      end else if (lce_req_ready_i) begin
        full_q <= 1'b0;
        data_q <= data_q;
      end else begin
        full_q <= full_q;
        data_q <= data_q;
      end
    end
  end

  assign req_ready_o = grant_s;
  assign lce_req_v_o = full_q;
  assign lce_req_o   = data_q;

  for (genvar i = 0; i < int'(num_req_p); i++) begin : g_credit
    bp_lce_req_arb_credit #(
      .credits_p (credits_p)
    ) u_credit (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (grant_s[i]),
      .dec_i   (credit_return_i[i]),
      .full_o  (credits_full_o[i]),
      .empty_o (credits_empty_o[i])
    );
  end

`ifdef BP_LCE_REQ_ARB_STATS_EN
  logic [num_req_p*grant_cnt_width_lp-1:0] grant_cnt_q;

  // Per-requester grant counters; they wrap at 2^32.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(num_req_p); i++) begin
        if (grant_s[i]) begin
          grant_cnt_q[i*grant_cnt_width_lp +: grant_cnt_width_lp] <=
            grant_cnt_q[i*grant_cnt_width_lp +: grant_cnt_width_lp] + 32'd1;
        end else begin
          grant_cnt_q[i*grant_cnt_width_lp +: grant_cnt_width_lp] <=
            grant_cnt_q[i*grant_cnt_width_lp +: grant_cnt_width_lp];
        end
      end
    end
  end

  assign grant_count_o = grant_cnt_q;
`else
  assign grant_count_o = '0;
`endif

  bp_lce_req_arb_chk #(
    .num_req_p (num_req_p)
  ) u_chk (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_ready_i     (grant_s),
    .credit_return_i (credit_return_i),
    .credits_empty_i (credits_empty_o),
    .credits_full_i  (credits_full_o)
  );

endmodule

// File: tb/tb_bp_lce_req_arb.sv
// Directed bench for bp_lce_req_arb: two requesters, two credits each, 16-bit payloads.
module tb_bp_lce_req_arb;

  localparam int unsigned N = 2;
  localparam int unsigned C = 2;
  localparam int unsigned W = 16;

  logic           clk;
  logic           reset;
  logic [W-1:0]   p0, p1;
  logic [N*W-1:0] req_s;
  logic [N-1:0]   req_v;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   ret;
  logic [N-1:0]   cfull;
  logic [N-1:0]   cempty;
  logic [W-1:0]   lce_req;
  logic           lce_v;
  logic           lready;
  logic [N*32-1:0] gcount;

  int errs;
  int checks;

  assign req_s = {p1, p0};

  bp_lce_req_arb #(
    .num_req_p   (N),
    .credits_p   (C),
    .req_width_p (W)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .req_i           (req_s),
    .req_v_i         (req_v),
    .req_ready_o     (req_ready),
    .credit_return_i (ret),
    .credits_full_o  (cfull),
    .credits_empty_o (cempty),
    .lce_req_o       (lce_req),
    .lce_req_v_o     (lce_v),
    .lce_req_ready_i (lready),
    .grant_count_o   (gcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational grant, then advance past the edge.
  task automatic cyc(input logic [1:0] v, input logic [1:0] r, input logic lr,
                     input logic [1:0] exp_rdy, input string tag);
    req_v  = v;
    ret    = r;
    lready = lr;
    #1;
    check(tag, 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic check_buf(input string tag, input logic v, input logic [W-1:0] d);
    check({tag, "_v"}, 64'(lce_v), 64'(v));
    check({tag, "_d"}, 64'(lce_req), 64'(d));
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    reset  = 1'b1;
    req_v  = 2'b11;
    ret    = 2'b00;
    lready = 1'b0;
    p0     = 16'hA000;
    p1     = 16'hB000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'h0);
    check_buf("rst_buf", 1'b0, 16'h0000);
    check("rst_empty", 64'(cempty), 64'h3);
    check("rst_full", 64'(cfull), 64'h0);
    check("rst_gcount", 64'(gcount), 64'h0);
    reset = 1'b0;
    req_v = 2'b00;

    // Both requesters contend: grants alternate until credits run out.
    cyc(2'b11, 2'b00, 1'b1, 2'b01, "alt0");
    check_buf("alt0", 1'b1, 16'hA000);
    p0 = 16'hA001;
    cyc(2'b11, 2'b00, 1'b1, 2'b10, "alt1");
    check_buf("alt1", 1'b1, 16'hB000);
    p1 = 16'hB001;
    cyc(2'b11, 2'b00, 1'b1, 2'b01, "alt2");
    check_buf("alt2", 1'b1, 16'hA001);
    check("alt2_full", 64'(cfull), 64'h1);
    p0 = 16'hA002;
    cyc(2'b11, 2'b00, 1'b1, 2'b10, "alt3");
    check_buf("alt3", 1'b1, 16'hB001);
    check("alt3_full", 64'(cfull), 64'h3);
    check("alt3_empty", 64'(cempty), 64'h0);
    p1 = 16'hB002;
    cyc(2'b11, 2'b00, 1'b1, 2'b00, "both_full");
    check("both_full_v", 64'(lce_v), 64'h0);

    // Credit returns re-enable exactly the returning requester.
    cyc(2'b11, 2'b10, 1'b1, 2'b00, "ret1_pend");
    check("ret1_full", 64'(cfull), 64'h1);
    cyc(2'b11, 2'b00, 1'b1, 2'b10, "only_r1");
    check_buf("only_r1", 1'b1, 16'hB002);
    p1 = 16'hB003;
    cyc(2'b11, 2'b01, 1'b1, 2'b00, "ret0_pend");
    check("ret0_v", 64'(lce_v), 64'h0);
    cyc(2'b11, 2'b00, 1'b1, 2'b01, "r0_again");
    check_buf("r0_again", 1'b1, 16'hA002);
    p0 = 16'hA003;

    // Transfer and return in the same cycle at count 1 leave the count at 1.
    cyc(2'b00, 2'b11, 1'b1, 2'b00, "ret_both");
    check("ret_both_full", 64'(cfull), 64'h0);
    check("ret_both_empty", 64'(cempty), 64'h0);
    cyc(2'b01, 2'b01, 1'b1, 2'b01, "inc_dec");
    check("inc_dec_full", 64'(cfull), 64'h0);
    check("inc_dec_empty", 64'(cempty), 64'h0);
    check_buf("inc_dec", 1'b1, 16'hA003);
    p0 = 16'hA004;
    cyc(2'b01, 2'b00, 1'b1, 2'b01, "inc_to_full");
    check("inc_to_full_f", 64'(cfull), 64'h1);
    p0 = 16'hA005;

    // Network stall: buffer holds, no grants until ready returns.
    cyc(2'b00, 2'b11, 1'b1, 2'b00, "ret_d");
    check("ret_d_empty", 64'(cempty), 64'h2);
    p1 = 16'hB005;
    cyc(2'b10, 2'b00, 1'b1, 2'b10, "stall_load");
    check_buf("stall_load", 1'b1, 16'hB005);
    p1 = 16'hB006;
    for (int s = 0; s < 3; s++) begin
      cyc(2'b11, 2'b00, 1'b0, 2'b00, "stall");
      check_buf("stall", 1'b1, 16'hB005);
    end
    cyc(2'b11, 2'b00, 1'b1, 2'b01, "stall_release");
    check_buf("stall_release", 1'b1, 16'hA005);
    p0 = 16'hA006;
    cyc(2'b00, 2'b00, 1'b1, 2'b00, "drain");
    check("drain_v", 64'(lce_v), 64'h0);

    // Reset with a full buffer, nonzero credits and pointer at 1.
    cyc(2'b00, 2'b01, 1'b1, 2'b00, "ret_e");
    cyc(2'b01, 2'b00, 1'b0, 2'b01, "load_e");
    check_buf("load_e", 1'b1, 16'hA006);
    req_v = 2'b00;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_buf("mid_rst", 1'b0, 16'h0000);
    check("mid_rst_empty", 64'(cempty), 64'h3);
    check("mid_rst_full", 64'(cfull), 64'h0);
    p0 = 16'hC000;
    cyc(2'b11, 2'b00, 1'b1, 2'b01, "ptr_reset");
    check_buf("ptr_reset", 1'b1, 16'hC000);

    // Back-to-back traffic: one message per cycle; 10 grants to 0, 7 to 1.
    for (int k = 1; k < 10; k++) begin
      p0 = 16'hC000 + 16'(k);
      cyc(2'b01, 2'b01, 1'b1, 2'b01, "stats_r0");
      check_buf("stats_r0", 1'b1, 16'hC000 + 16'(k));
    end
    p1 = 16'hD000;
    cyc(2'b10, 2'b00, 1'b1, 2'b10, "stats_r1_first");
    check_buf("stats_r1_first", 1'b1, 16'hD000);
    for (int k = 1; k < 7; k++) begin
      p1 = 16'hD000 + 16'(k);
      cyc(2'b10, 2'b10, 1'b1, 2'b10, "stats_r1");
      check_buf("stats_r1", 1'b1, 16'hD000 + 16'(k));
    end
    req_v = 2'b00;
    ret   = 2'b00;
`ifdef BP_LCE_REQ_ARB_STATS_EN
    check("gcount", 64'(gcount), {32'd7, 32'd10});
`else
    check("gcount", 64'(gcount), 64'h0);
`endif
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bp_lce_req_arb.md
# bp_lce_req_arb

Round-robin arbiter that shares one coherence-network LCE request link between `num_req_p` LCE request sources, for example the I-cache and D-cache LCEs of a tile. It buffers the granted message in a single-entry output register that sustains full throughput. It also keeps a per-requester outstanding-request credit counter, so no source exceeds `credits_p` transactions in flight. It sits between the per-cache LCE request handlers and the tile's coherence network injection port.

## Interface
- `bp_params_p`, `e_bp_default_cfg`: processor configuration; supplies the LCE request width.
- `num_req_p`, 2: number of requesters; range 1..8.
- `credits_p`, `coh_noc_max_credits_p`: maximum outstanding requests per requester.
- `req_width_p`, `lce_cce_req_width_lp`: payload width; the payload is opaque to this block.

Ports (all signals in the `clk_i` domain):
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `req_i`  in  `num_req_p*req_width_p`  requester payloads; requester i occupies slice i.
- `req_v_i`  in  `num_req_p`  requester valid.
- `req_ready_o`  out  `num_req_p`  accept strobe; at most one bit set; may depend on `req_v_i`.
- `credit_return_i`  in  `num_req_p`  one pulse per completed transaction, per requester.
- `credits_full_o`  out  `num_req_p`  the requester's count equals `credits_p`.
- `credits_empty_o`  out  `num_req_p`  the requester's count equals 0.
- `lce_req_o`  out  `req_width_p`  network payload.
- `lce_req_v_o`  out  1  network valid.
- `lce_req_ready_i`  in  1  network ready.
- `grant_count_o`  out  `num_req_p*32`  per-requester grant counters; see Configuration.

## Operation
- Requester handshake: a requester holds `req_v_i[i]` and its payload stable until it sees `req_ready_o[i]`. A transfer occurs in any cycle where `req_v_i[i] & req_ready_o[i]`.
- Eligibility: requester i is eligible when `req_v_i[i]`, not `credits_full_o[i]`, and the buffer can load. The buffer can load when it is empty, or when it is full and `lce_req_ready_i` is high.
- Arbitration: among eligible requesters, grant the first one found scanning upward from the priority pointer, wrapping past `num_req_p-1` to 0.
- Pointer update: only on a transfer, the pointer becomes (granted index + 1) mod `num_req_p`. With no transfer, the pointer is unchanged.
- Output buffer states:
  - EMPTY goes to FULL on a transfer.
  - FULL goes to EMPTY when `lce_req_ready_i` is high and there is no transfer.
  - FULL stays FULL with new data when the network drains and a transfer happens in the same cycle.
  - FULL holds otherwise. `lce_req_v_o` equals FULL.
- Credit counter i, width `BSG_WIDTH(credits_p)`:
  - +1 on transfer i; -1 on `credit_return_i[i]`; unchanged when both occur in the same cycle.
  - A return while the count is 0 is illegal; it saturates at 0 and is flagged by an assertion.
  - A transfer is never granted at `credits_p`.
- With `num_req_p` = 1 the arbitration degenerates to a grant of requester 0 whenever it is eligible.

## Timing
- Reset values:
  - `req_ready_o` = 0, `lce_req_v_o` = 0, `lce_req_o` = 0.
  - All credit counters = 0, so `credits_empty_o` = all ones and `credits_full_o` = 0.
  - Priority pointer = 0; `grant_count_o` = 0.
- Reset asserted mid-operation discards any buffered message and all credits, with no network traffic afterward. Requesters must also be reset.
- Latency: a transfer in cycle t gives `lce_req_v_o` high in cycle t+1. There is no combinational path from `req_i` to `lce_req_o`.
- Throughput: one message per cycle while `lce_req_ready_i` stays high.
- `lce_req_v_o` never deasserts and `lce_req_o` never changes while `lce_req_ready_i` is low.
- `credits_full_o` and `credits_empty_o` are registered-count decodes; they update the cycle after the transfer or return.
- `req_ready_o` depends combinationally on `req_v_i`, `lce_req_ready_i` and registered state only.

## Configuration
- `BP_LCE_REQ_ARB_STATS_EN` defined:
  - Each requester has a 32-bit grant counter that increments on that requester's transfer and wraps at 2^32.
  - The counters appear on `grant_count_o`.
- Not defined: `grant_count_o` is tied to 0 and no counter flops are built. Arbitration, credit and buffer behaviour are identical in both builds.

## Structure
- No new typedefs are needed. Widths come from the `bp_common_pkg` LCE–CCE interface macros.
- The output buffer state can be a single valid bit; it needs no enum in a package.
- Use the existing `bsg_arb_round_robin` for grant selection, fed with the eligibility vector, `yumi_i` = transfer.
- Credit counters are `num_req_p` instances of the existing `bsg_flow_counter`.
- Output buffer and stats counters are local flops.

## Test plan
- Requesters 0 and 1 valid every cycle, `lce_req_ready_i`=1 -> grants alternate 0,1,0,1 and there is one network message per cycle.
- Requester 1 raises valid at cycle 5 and `lce_req_ready_i` is held 0 for 3 cycles -> `lce_req_v_o` is high from cycle 6 with stable payload until ready returns. No further `req_ready_o` is given during the stall, except in the cycle ready returns.
- `credits_p`=2, requester 0 sends twice with no return -> `credits_full_o[0]`=1 and requester 1 alone is granted. Returning one credit -> requester 0 is granted again on the next eligible cycle.
- Transfer and `credit_return_i[0]` in the same cycle at count 1 -> count stays 1.
- Reset asserted while the buffer is full and counts are nonzero -> the next cycle has `lce_req_v_o`=0, all counts 0 and the pointer at 0.
- With `BP_LCE_REQ_ARB_STATS_EN`, 10 grants to 0 and 7 to 1 -> `grant_count_o` slices read 10 and 7. Without the macro -> `grant_count_o` reads 0.
